core_fetch_prefetch: RTL and testbench

//  Prefetching instruction-fetch unit between I-mem and the EXEC stage. Streams sequential fetches

---
 rtl/core_fetch_prefetch_if.sv | 36 +++
 rtl/core_fetch_prefetch.sv | 94 +++++++++
 tb/tb_core_fetch_prefetch.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/core_fetch_prefetch_if.sv
// Fetch-unit bundle: EXEC-side instruction queue head, redirect inputs, I-mem request
// channel, interrupt blocks and queue occupancy. master = fetch unit, slave = its environment.
interface core_fetch_prefetch_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [31:0]      pc_plus_4;
    logic             pc_new_valid;
    logic [31:0]      pc_new;
    logic             pc_csr_valid;
    logic [31:0]      pc_csr;
    logic             imem_valid;
    logic             imem_ready;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic             m_interrupt_valid;
    logic             s_interrupt_valid;
    logic [CNT_W-1:0] queue_count;

    modport master (
        output instr_valid, instr, pc, pc_plus_4, imem_valid, imem_addr, queue_count,
        input  instr_ready, pc_new_valid, pc_new, pc_csr_valid, pc_csr,
               imem_ready, imem_rdata, m_interrupt_valid, s_interrupt_valid
    );

    modport slave (
        input  instr_valid, instr, pc, pc_plus_4, imem_valid, imem_addr, queue_count,
        output instr_ready, pc_new_valid, pc_new, pc_csr_valid, pc_csr,
               imem_ready, imem_rdata, m_interrupt_valid, s_interrupt_valid
    );
endinterface

// File: rtl/core_fetch_prefetch.sv
// Prefetching fetch unit: streams sequential I-mem reads into a DEPTH-entry {instr, pc}
// queue; EXEC/CSR redirects flush the queue and restart fetch at the (word-aligned) target.
module core_fetch_prefetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned DEPTH        = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    core_fetch_prefetch_if.master bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t           queue_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;

    logic        redirect;
    logic        irq_pending;
    logic        full;
    logic        fetch_done;
    logic        deq;
    logic [31:0] target;

    assign redirect    = bus.pc_csr_valid | bus.pc_new_valid;
    assign target      = bus.pc_csr_valid ? {bus.pc_csr[31:2], 2'b00}
                                          : {bus.pc_new[31:2], 2'b00};
    assign irq_pending = bus.m_interrupt_valid | bus.s_interrupt_valid;
    // Full uses registered count only, so a same-cycle dequeue never opens a fetch slot.
    assign full        = (count_q == CNT_W'(DEPTH));
    assign fetch_done  = bus.imem_valid & bus.imem_ready;
    assign deq         = bus.instr_valid & bus.instr_ready;

    assign bus.imem_valid  = ~redirect & ~full & ~irq_pending;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = queue_q[rd_ptr_q].instr;
    assign bus.pc          = queue_q[rd_ptr_q].pc;
    assign bus.pc_plus_4   = queue_q[rd_ptr_q].pc + 32'd4;
    assign bus.queue_count = count_q;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = target;
        end else begin
            if (fetch_done) begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({fetch_done, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_VECTOR;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fetch_done) begin
            queue_q[wr_ptr_q] <= '{instr: bus.imem_rdata, pc: fetch_pc_q};
        end
    end
endmodule

// File: tb/tb_core_fetch_prefetch.sv
// Directed bench for core_fetch_prefetch: fill/stall, streaming, redirects, CSR priority,
// interrupt drain, PC wrap and asynchronous reset, with hand-computed expectations.
module tb_core_fetch_prefetch;
    logic clk;
    logic rst_n;
    int unsigned n_chk;
    int unsigned n_pass;

    core_fetch_prefetch_if #(.DEPTH(4)) bus ();

    core_fetch_prefetch #(
        .RESET_VECTOR(32'h0000_0000),
        .DEPTH       (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs may be changed #1 later, outputs sampled #2 after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        bus.instr_ready       = 1'b0;
        bus.pc_new_valid      = 1'b0;
        bus.pc_new            = '0;
        bus.pc_csr_valid      = 1'b0;
        bus.pc_csr            = '0;
        bus.imem_ready        = 1'b0;
        bus.m_interrupt_valid = 1'b0;
        bus.s_interrupt_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_count",       32'(bus.queue_count), 32'd0);
        check("rst_imem_addr",   bus.imem_addr, 32'h0);
        check("rst_imem_valid",  32'(bus.imem_valid), 32'd1);

        // Fill with EXEC stalled
        bus.imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fill_addr",  bus.imem_addr, 32'(4 * i));
            check("fill_valid", 32'(bus.imem_valid), 32'd1);
            tick();
            check("fill_count", 32'(bus.queue_count), 32'(i + 1));
            check("fill_ivalid", 32'(bus.instr_valid), 32'd1);
        end
        check("full_imem_valid", 32'(bus.imem_valid), 32'd0);
        check("full_pc",    bus.pc, 32'h0);
        check("full_instr", bus.instr, 32'hA5A5_0000);
        check("full_pc4",   bus.pc_plus_4, 32'h4);

        // Streaming: full blocks the first cycle even though a dequeue happens
        bus.instr_ready = 1'b1;
        #1;
        check("full_deq_imem_valid", 32'(bus.imem_valid), 32'd0);
        #1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("strm_pc",    bus.pc, 32'(4 * (k + 1)));
            check("strm_instr", bus.instr, 32'(4 * (k + 1)) ^ 32'hA5A5_0000);
            check("strm_pc4",   bus.pc_plus_4, 32'(4 * (k + 2)));
            check("strm_addr",  bus.imem_addr, 32'h10 + 32'(4 * k));
            check("strm_count", 32'(bus.queue_count), 32'd3);
        end

        // EXEC redirect flushes a full queue
        bus.instr_ready = 1'b0;
        tick();
        check("pre_redir_count", 32'(bus.queue_count), 32'd4);
        check("pre_redir_pc",    bus.pc, 32'h10);
        bus.pc_new_valid = 1'b1;
        bus.pc_new       = 32'h200;
        #1;
        check("redir_imem_valid", 32'(bus.imem_valid), 32'd0);
        @(posedge clk);
        #1 bus.pc_new_valid = 1'b0;
        #1;
        check("redir_count",  32'(bus.queue_count), 32'd0);
        check("redir_ivalid", 32'(bus.instr_valid), 32'd0);
        check("redir_addr",   bus.imem_addr, 32'h200);
        check("redir_ivalid_imem", 32'(bus.imem_valid), 32'd1);
        tick();
        check("redir_head_pc",    bus.pc, 32'h200);
        check("redir_head_instr", bus.instr, 32'hA5A5_0200);
        check("redir_head_count", 32'(bus.queue_count), 32'd1);

        // CSR redirect wins over EXEC redirect
        bus.pc_csr_valid = 1'b1;
        bus.pc_csr       = 32'h8000_0000;
        bus.pc_new_valid = 1'b1;
        bus.pc_new       = 32'h100;
        #1;
        check("prio_imem_valid", 32'(bus.imem_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.pc_csr_valid = 1'b0;
        bus.pc_new_valid = 1'b0;
        #1;
        check("prio_addr",  bus.imem_addr, 32'h8000_0000);
        check("prio_count", 32'(bus.queue_count), 32'd0);
        tick();
        check("prio_head_pc", bus.pc, 32'h8000_0000);
        tick();
        tick();
        check("irq_pre_count", 32'(bus.queue_count), 32'd3);

        // Interrupt pending: no fetch, queue drains in order
        bus.m_interrupt_valid = 1'b1;
        bus.instr_ready       = 1'b1;
        #1;
        check("irq_imem_valid", 32'(bus.imem_valid), 32'd0);
        check("irq_head0",      bus.pc, 32'h8000_0000);
        #1;
        for (int j = 1; j <= 3; j++) begin
            tick();
            check("irq_count",      32'(bus.queue_count), 32'(3 - j));
            check("irq_imem_valid", 32'(bus.imem_valid), 32'd0);
            if (j < 3) check("irq_head", bus.pc, 32'h8000_0000 + 32'(4 * j));
        end
        check("irq_empty_ivalid", 32'(bus.instr_valid), 32'd0);
        check("irq_hold_addr",    bus.imem_addr, 32'h8000_000C);
        bus.s_interrupt_valid = 1'b1;
        bus.m_interrupt_valid = 1'b0;
        #1;
        check("sirq_imem_valid", 32'(bus.imem_valid), 32'd0);

        // CSR redirect near the top of the address space, then free-running wrap
        bus.s_interrupt_valid = 1'b0;
        bus.pc_csr_valid      = 1'b1;
        bus.pc_csr            = 32'hFFFF_FFF8;
        #1;
        check("wrap_redir_imem_valid", 32'(bus.imem_valid), 32'd0);
        @(posedge clk);
        #1 bus.pc_csr_valid = 1'b0;
        #1;
        check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFF8);
        tick();
        check("wrap_head0", bus.pc, 32'hFFFF_FFF8);
        check("wrap_addr1", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_head1", bus.pc, 32'hFFFF_FFFC);
        check("wrap_pc4",   bus.pc_plus_4, 32'h0);
        check("wrap_addr2", bus.imem_addr, 32'h0);
        tick();
        check("wrap_head2", bus.pc, 32'h0);
        check("wrap_cnt",   32'(bus.queue_count), 32'd1);

        // Misaligned redirect target is forced to word alignment
        bus.pc_new_valid = 1'b1;
        bus.pc_new       = 32'h103;
        @(posedge clk);
        #1 bus.pc_new_valid = 1'b0;
        #1;
        check("align_addr",  bus.imem_addr, 32'h100);
        check("align_count", 32'(bus.queue_count), 32'd0);
        tick();
        tick();
        check("pre_rst_count", 32'(bus.queue_count), 32'd1);

        // Asynchronous reset mid-operation
        #1 rst_n = 1'b0;
        #1;
        check("arst_count",  32'(bus.queue_count), 32'd0);
        check("arst_ivalid", 32'(bus.instr_valid), 32'd0);
        check("arst_addr",   bus.imem_addr, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
